sigma_delta_decimator: RTL
==========================

// Module: sigma_delta_decimator
// PURPOSE
// - Receive side of the audio sigma-delta path: turns a 1-bit bitstream (e.g. from an
//   external sigma-delta ADC or a looped-back DAC output) into signed PCM samples.
// - Uses a 2nd-order CIC (sinc^2) decimator with ratio R = 2**LOG2_R.
// - Output format matches the DAC input word: signed NBITS.MBITS fixed point, +1.0 = 1<<MBITS.
// PARAMETERS
// - NBITS   2   integer bits of dout, sign included; must be >= 2.
// - MBITS   16  fractional bits of dout.
// - LOG2_R  4   log2 of the decimation ratio; R = 16. Constraint: 2*LOG2_R <= MBITS.
// PORTS
// - clk         in   1              system clock
// - reset       in   1              reset, asynchronous, active-high
// - din         in   1              bitstream bit; 1 = +1.0, 0 = -1.0
// - din_valid   in   1              din is sampled on clocks where this is high (oversample strobe)
// - dout        out  NBITS+MBITS    signed PCM sample, NBITS.MBITS
// - dout_valid  out  1              single-cycle pulse; dout is valid while it is high
// BEHAVIOUR
// - Widths: W = 2*LOG2_R+2. Integrators i1, i2 and comb registers are W bits and wrap
//   modulo 2**W. Wrap is intentional and exact for the CIC.
// - Input map: x = din ? +1 : -1, as a W-bit signed value.
// - On each din_valid:
//     i1 <= i1 + x;  i2 <= i2 + i1 (old i1);  cnt <= cnt+1 mod R.
// - Frame tick: a registered flag, high for exactly one cycle after the strobe that takes
//   cnt from R-1 to 0.
// - On the tick cycle, the comb samples the current i2, which holds exactly R*k strobes:
//     c1 = i2 - i2_d;  c2 = c1 - c1_d;
//     i2_d <= i2;  c1_d <= c1;
//     dout <= sext(c2) << (MBITS - 2*LOG2_R);  dout_valid <= 1.
// - Latency: dout_valid rises 2 clocks after the R-th strobe of a frame. Otherwise dout_valid=0.
// - dout holds its value between pulses.
// - Steady-state gain is R**2, so constant 1s give exactly +1.0 and constant 0s give -1.0.
//   No saturation is required; the full range is representable.
// - din_valid on the tick cycle is legal. The integrators update normally and the comb uses
//   the pre-update i2.
// - Gaps in din_valid (any pattern) must not change the output sequence, only its timing.
// - Reset (async, any time, including mid-frame) clears i1, i2, cnt, tick, i2_d, c1_d,
//   dout=0, dout_valid=0. The next output follows R fresh strobes after reset release.
// - Warm-up: the first output after reset is a transient, (R*(R-1)/2) for all-1s input.
//   It is correct from the 2nd output onward.
// CONFIGURATION
// - SIGMA_DELTA_DEC_WARMUP_MASK_EN defined:
//   - dout_valid is suppressed for the first 2 frame ticks after reset.
//   - dout and the comb registers still update on those ticks.
//   - A 2-bit saturating warm-up counter is reset with everything else.
// - Undefined: every frame tick produces a dout_valid pulse, transients included.
// TESTING (NBITS=2, MBITS=16, LOG2_R=4 -> R=16, shift 8; mask undefined unless noted)
// - Constant din=1, din_valid=1: dout seq 30720 (0x07800), then 65536 (0x10000) every
//   16 clks; dout_valid 2 clks after each 16th strobe.
// - Constant din=0: 30720 negated (0x38800), then 0x30000 (-65536) repeating.
// - Alternating 1,0,1,0...: first dout 2048, then 0 on every later frame.
// - Same as the first case with din_valid high 1 clk in 3: identical dout values, one pulse
//   per 16 strobes, dout_valid never high 2 cycles in a row.
// - Reset asserted after 7 strobes of a frame, then constant 1s: dout_valid=0 and dout=0
//   during reset. Next pulse after 16 new strobes, value 30720.
// - SIGMA_DELTA_DEC_WARMUP_MASK_EN, constant 1s: first 2 ticks give no dout_valid. The
//   first pulse has dout=65536 and all later pulses are 65536.

Source files
------------

// File: rtl/sigma_delta_decimator.sv
// sigma_delta_decimator: sinc^2 CIC decimator, 1-bit bitstream -> signed NBITS.MBITS PCM, ratio 2**LOG2_R.
// dout_valid pulses 2 clks after each R-th strobe; define SIGMA_DELTA_DEC_WARMUP_MASK_EN to hide the first 2 outputs.
module sigma_delta_decimator #(
  parameter int NBITS  = 2,
  parameter int MBITS  = 16,
  parameter int LOG2_R = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   din,
  input  logic                   din_valid,
  output logic [NBITS+MBITS-1:0] dout,
  output logic                   dout_valid
);

  localparam int W  = 2*LOG2_R + 2;
  localparam int DW = NBITS + MBITS;
  localparam int SH = MBITS - 2*LOG2_R;

  logic signed [W-1:0]  i1, i2, i2_d, c1_d;
  logic signed [W-1:0]  x, c1, c2;
  logic signed [DW-1:0] c2_ext;
  logic [LOG2_R-1:0]    cnt;
  logic                 tick;
  logic                 open;

  // All arithmetic wraps modulo 2**W; the comb differences cancel the wrap exactly.
  assign x      = din ? W'(1) : '1;
  assign c1     = i2 - i2_d;
  assign c2     = c1 - c1_d;
  assign c2_ext = DW'($signed(c2));

`ifdef SIGMA_DELTA_DEC_WARMUP_MASK_EN
  logic [1:0] warm;

  // Saturates at 2: the first two frame ticks carry the integrator start-up transient.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm <= 2'd0;
    end else if (tick && warm != 2'd2) begin
      warm <= warm + 2'd1;
    end
  end

  assign open = (warm == 2'd2);
`else
  assign open = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1         <= '0;
      i2         <= '0;
      cnt        <= '0;
      tick       <= 1'b0;
      i2_d       <= '0;
      c1_d       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      tick       <= din_valid && (cnt == '1);
      dout_valid <= 1'b0;
      if (din_valid) begin
        i1  <= i1 + x;
        i2  <= i2 + i1;
        cnt <= cnt + LOG2_R'(1);
      end
      // Comb runs on the tick cycle from the pre-update i2, even if a strobe lands here.
      if (tick) begin
        i2_d       <= i2;
        c1_d       <= c1;
        dout       <= c2_ext <<< SH;
        dout_valid <= open;
      end
    end
  end

endmodule
